bp_cce_hybrid_pending_counters: RTL
===================================

Name: bp_cce_hybrid_pending_counters

Overview:
- Multi-port pending-counter array for the hybrid CCE. Tracks one counter per way group managed by this CCE.
- Two write ports: port 0 on the LCE request side, port 1 on the memory/response side. Each port may increment, decrement or clear.
- Both write ports can hit the same way group in one cycle; their effects are merged.
- Counters saturate instead of wrapping and raise sticky error flags.
- Provides a parametrised number of asynchronous read ports and a registered count of busy way groups, used by the CCE for drain/quiesce decisions.

Parameters:
- num_way_groups_p, none (required), way groups managed by this CCE
- cce_way_groups_p, none (required), total way groups in the system
- num_cce_p, none (required), CCE count; bsg_hash_bank banks
- paddr_width_p, none (required), physical address width
- addr_offset_p, none (required), LSB of the way-group field in the address
- width_p, 3, counter width; max count = 2^width_p-1
- num_rd_ports_p, 2, number of read ports (>=1)
- lg_num_way_groups_lp, derived, `BSG_SAFE_CLOG2(num_way_groups_p)
- busy_width_lp, derived, `BSG_WIDTH(num_way_groups_p)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- w_v_i  in  2  per-write-port valid
- w_addr_i  in  2 x paddr_width_p  write address
- w_addr_bypass_hash_i  in  2  address LSBs are the way-group index directly
- w_op_i  in  2 x 2  operation: 01 up, 10 down, 11 clear, 00 illegal when valid
- r_v_i  in  num_rd_ports_p  read valid
- r_addr_i  in  num_rd_ports_p x paddr_width_p  read address
- r_addr_bypass_hash_i  in  num_rd_ports_p  bypass hash
- pending_o  out  num_rd_ports_p  count != 0; 0 when r_v_i=0
- count_o  out  num_rd_ports_p x width_p  counter value; 0 when r_v_i=0
- busy_count_o  out  busy_width_lp  registered number of nonzero counters
- overflow_o  out  1  sticky: a saturation at max occurred
- underflow_o  out  1  sticky: a saturation at 0 occurred
- err_wg_o  out  lg_num_way_groups_lp  way group of the first error since the last err_clear_i
- err_clear_i  in  1  clears overflow_o, underflow_o and err_wg_o

Behaviour:
- Address to way group: same mapping on every port. Bit-reverse addr[addr_offset_p +: lg(cce_way_groups_p)], then take bsg_hash_bank index_o. If bypass is set, use addr[0 +: lg_num_way_groups_lp] instead.
- Reset (reset_n_i low, asynchronous): all counters 0, busy_count_o=0, overflow_o=0, underflow_o=0, err_wg_o=0. Read outputs are combinational from the cleared state, so they read 0.
- Write resolution, per way group g, every cycle:
  - base = 0 if any valid port targets g with clear, else cur[g].
  - delta = (# valid ports targeting g with up) - (# with down), range -2..+2.
  - raw = base + delta, computed at width_p+2 signed.
  - raw > max: next = max, set overflow. raw < 0: next = 0, set underflow. Otherwise next = raw.
  - Clear is applied before up/down, including when clear and up/down come from different ports.
  - Up and down to the same g in one cycle cancel; no error is flagged even if cur=0 or cur=max.
- All counter updates take effect at the next posedge. Write-to-read latency is 1 cycle (no forwarding, unless the optional feature is enabled).
- busy_count_o: registered. Next value = current + (# g going 0->nonzero) - (# g going nonzero->0). It must always equal the popcount of (counters != 0).
- Error flags:
  - Set on the cycle after the saturating write.
  - err_wg_o captures g only when no error is already latched. When two way groups saturate in the same cycle, the one hit by port 0 wins.
  - If err_clear_i and a new error occur in the same cycle, the new error is latched.
- Illegal op (w_v_i with op 00): no state change; simulation-only $error.

Optional Feature:
- BP_CCE_PENDING_FWD_EN defined: pending_o and count_o are driven from the next-state value, giving 0-cycle write-to-read forwarding. This adds a combinational path from w_* to the read outputs.
- Not defined: read outputs are driven from registered state only.
- busy_count_o and the error flags are registered in both cases.

Test Plan:
- Reset release, then read wg 5 (bypass) -> pending_o=0, count_o=0, busy_count_o=0.
- Port 0 up on wg 3 for 3 cycles -> count_o=3, busy_count_o=1. Same-cycle read returns the pre-write value without FWD_EN, the post-write value with it.
- Same cycle: port 0 up wg 2, port 1 down wg 2, with count=0 -> count stays 0, underflow_o=0.
- width_p=3, wg 1 at 7, port 0 up -> count stays 7, overflow_o=1, err_wg_o=1. A later underflow on wg 4 leaves err_wg_o=1. err_clear_i -> all error outputs 0.
- wg 6 at 4: port 0 clear and port 1 up in the same cycle -> count=1. Then port 1 down -> count=0, busy_count_o decrements.
- Assert reset_n_i mid-stream with 3 busy wgs -> all outputs 0 immediately; the first write after release sees count 0.

Source files
------------

// File: rtl/bp_cce_hybrid_pending_counters.sv
// -----------------------------------------------------------------------------
// bp_cce_hybrid_pending_counters
//
// This module keeps a pending-transaction counter for each way group owned by
// this CCE. Two write ports can change the counters in the same cycle:
//   port 0 - LCE request side
//   port 1 - memory/response side
// Each port can increment, decrement or clear a counter. Counters saturate
// instead of wrapping. A saturation sets a sticky overflow or underflow flag
// and records the offending way group.
//
// Optional feature macro:
//   BP_CCE_PENDING_FWD_EN - when defined, the read ports return the next-state
//   counter value. This gives 0-cycle write-to-read forwarding and adds a
//   combinational path from w_* to the read outputs. When it is not defined,
//   the read ports return registered state only.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   w_v_i[2]                 write valid, one bit per port
//   w_addr_i[2]              write address, one per port
//   w_addr_bypass_hash_i[2]  address LSBs are the way-group index directly
//   w_op_i[2]                01 up, 10 down, 11 clear, 00 illegal
//   r_v_i, r_addr_i,         read ports; the outputs read 0 when r_v_i is low
//   r_addr_bypass_hash_i
//   pending_o, count_o       per read port: counter != 0 and counter value
//   busy_count_o             registered number of nonzero counters
//   overflow_o, underflow_o  sticky saturation flags
//   err_wg_o                 way group of the first error since the last clear
//   err_clear_i              clears overflow_o, underflow_o and err_wg_o
// -----------------------------------------------------------------------------
module bp_cce_hybrid_pending_counters #(
    parameter int num_way_groups_p = 8,
    parameter int cce_way_groups_p = 16,
    parameter int num_cce_p        = 2,
    parameter int paddr_width_p    = 40,
    parameter int addr_offset_p    = 6,
    parameter int width_p          = 3,
    parameter int num_rd_ports_p   = 2,
    localparam int lg_num_way_groups_lp = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1,
    localparam int busy_width_lp        = $clog2(num_way_groups_p + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [1:0]                                    w_v_i,
    input  logic [1:0][paddr_width_p-1:0]                 w_addr_i,
    input  logic [1:0]                                    w_addr_bypass_hash_i,
    input  logic [1:0][1:0]                               w_op_i,
    input  logic [num_rd_ports_p-1:0]                     r_v_i,
    input  logic [num_rd_ports_p-1:0][paddr_width_p-1:0]  r_addr_i,
    input  logic [num_rd_ports_p-1:0]                     r_addr_bypass_hash_i,
    output logic [num_rd_ports_p-1:0]                     pending_o,
    output logic [num_rd_ports_p-1:0][width_p-1:0]        count_o,
    output logic [busy_width_lp-1:0]                      busy_count_o,
    output logic                                          overflow_o,
    output logic                                          underflow_o,
    output logic [lg_num_way_groups_lp-1:0]               err_wg_o,
    input  logic                                          err_clear_i
);

    localparam int lg_cce_way_groups_lp = (cce_way_groups_p > 1) ? $clog2(cce_way_groups_p) : 1;

    typedef logic [lg_num_way_groups_lp-1:0] wg_t;
    typedef logic [width_p-1:0]              cnt_t;
    // Two extra bits: one for the carry above max, one for the sign below zero.
    typedef logic signed [width_p+1:0]       raw_t;

    localparam cnt_t max_count_lp = '1;

    // The way-group field is bit-reversed and then banked across the CCEs, in
    // the same way as bsg_hash_bank. The local index is the hashed value
    // divided by the bank count. For a power-of-two bank count, this is the
    // same as dropping the low bank-select bits.
    function automatic wg_t addr_to_wg(input logic [paddr_width_p-1:0] addr, input logic bypass);
        logic [lg_cce_way_groups_lp-1:0] field;
        logic [lg_cce_way_groups_lp-1:0] rev;
        field = addr[addr_offset_p +: lg_cce_way_groups_lp];
        for (int i = 0; i < lg_cce_way_groups_lp; i++) begin
            rev[i] = field[lg_cce_way_groups_lp-1-i];
        end
        if (bypass) begin
            addr_to_wg = addr[0 +: lg_num_way_groups_lp];
        end else begin
            addr_to_wg = wg_t'(int'(rev) / num_cce_p);
        end
    endfunction

    cnt_t [num_way_groups_p-1:0] cnt_q, cnt_d;
    logic [busy_width_lp-1:0]    busy_q, busy_d;
    logic                        overflow_q, overflow_d;
    logic                        underflow_q, underflow_d;
    wg_t                         err_wg_q, err_wg_d;

    wg_t  [1:0]                  w_wg;
    logic [1:0]                  w_up, w_dn, w_clr, hit;
    logic [num_way_groups_p-1:0] ovf_g, unf_g;
    raw_t                        raw;
    logic                        any_ovf, any_unf, sat0;

    // Decode the write ports. Op 00 matches no decode, so it has no effect.
    always_comb begin
        // NOTE: every always_comb output gets a default first; otherwise a path that skips the assignment infers a latch.
        w_wg  = '0;
        w_up  = '0;
        w_dn  = '0;
        w_clr = '0;
        for (int p = 0; p < 2; p++) begin
            w_wg[p]  = addr_to_wg(w_addr_i[p], w_addr_bypass_hash_i[p]);
            w_up[p]  = w_v_i[p] && (w_op_i[p] == 2'b01);
            w_dn[p]  = w_v_i[p] && (w_op_i[p] == 2'b10);
            w_clr[p] = w_v_i[p] && (w_op_i[p] == 2'b11);
        end
    end

    // Per-way-group merge: clear first, then the net up/down delta, then
    // saturate. Opposite up and down requests cancel before the limit check.
    always_comb begin
        cnt_d = cnt_q;
        ovf_g = '0;
        unf_g = '0;
        raw   = '0;
        hit   = '0;
        for (int g = 0; g < num_way_groups_p; g++) begin
            for (int p = 0; p < 2; p++) begin
                hit[p] = (w_wg[p] == wg_t'(g));
            end
            raw = (|(w_clr & hit)) ? raw_t'(0) : raw_t'({2'b00, cnt_q[g]});
            for (int p = 0; p < 2; p++) begin
                if (w_up[p] && hit[p]) raw = raw + raw_t'(1);
                if (w_dn[p] && hit[p]) raw = raw - raw_t'(1);
            end
            if (raw > raw_t'({2'b00, max_count_lp})) begin
                cnt_d[g] = max_count_lp;
                ovf_g[g] = 1'b1;
            end else if (raw < raw_t'(0)) begin
                cnt_d[g] = '0;
                unf_g[g] = 1'b1;
            end else begin
                cnt_d[g] = cnt_t'(raw);
            end
        end
    end

    // The busy count follows zero/nonzero transitions, so it always equals
    // the popcount of the nonzero counters.
    always_comb begin
        busy_d = busy_q;
        for (int g = 0; g < num_way_groups_p; g++) begin
            if ((cnt_q[g] == '0) && (cnt_d[g] != '0)) begin
                busy_d = busy_d + busy_width_lp'(1);
            end else if ((cnt_q[g] != '0) && (cnt_d[g] == '0)) begin
                busy_d = busy_d - busy_width_lp'(1);
            end
        end
    end

    // Error capture. If both ports saturate, the way group of port 0 wins. A
    // new error in the same cycle as err_clear_i is kept.
    always_comb begin
        any_ovf     = |ovf_g;
        any_unf     = |unf_g;
        sat0        = (w_up[0] | w_dn[0] | w_clr[0]) && (ovf_g[w_wg[0]] | unf_g[w_wg[0]]);
        overflow_d  = (overflow_q  & ~err_clear_i) | any_ovf;
        underflow_d = (underflow_q & ~err_clear_i) | any_unf;
        err_wg_d    = err_clear_i ? wg_t'(0) : err_wg_q;
        if ((any_ovf || any_unf) && (err_clear_i || !(overflow_q || underflow_q))) begin
            err_wg_d = sat0 ? w_wg[0] : w_wg[1];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: the counters are a small flop array with a defined reset state, so they reset with the control state.
        if (!reset_n_i) begin
            cnt_q       <= '0;
            busy_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            err_wg_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            err_wg_q    <= err_wg_d;
        end
    end

    cnt_t [num_way_groups_p-1:0] rd_src;
`ifdef BP_CCE_PENDING_FWD_EN
    assign rd_src = cnt_d;
`else
    assign rd_src = cnt_q;
`endif

    always_comb begin
        pending_o = '0;
        count_o   = '0;
        for (int r = 0; r < num_rd_ports_p; r++) begin
            if (r_v_i[r]) begin
                count_o[r]   = rd_src[addr_to_wg(r_addr_i[r], r_addr_bypass_hash_i[r])];
                pending_o[r] = |count_o[r];
            end
        end
    end

    assign busy_count_o = busy_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;
    assign err_wg_o     = err_wg_q;

`ifndef SYNTHESIS
    for (genvar p = 0; p < 2; p++) begin : g_illegal_op_chk
        assert property (@(posedge clk_i) disable iff (!reset_n_i)
                         !(w_v_i[p] && (w_op_i[p] == 2'b00)))
            else $error("illegal op 00 on write port %0d", p);
    end
`endif

endmodule
